pipe_hazard_ctrl: RTL and testbench
===================================

// Module: pipe_hazard_ctrl
// PURPOSE
// - Central stall/flush generator for the 5-stage MIPS pipeline. Drives the we/flush pins of the
//   IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, plus the PC write enable.
// - Handles load-use interlock, branch/jump redirect flush and data-memory wait freeze.
// - Tracks multi-cycle MULT/DIV occupancy with an internal busy timer.
// - Pipeline-register contract: flush clears a register only when its we=1. Every bubble is
//   therefore issued as we=1 with flush=1; a hold is issued as we=0.
// PARAMETERS
// - MULT_LAT  5   cycles HI/LO busy after MULT/MULTU leaves EX (1..31)
// - DIV_LAT   32  cycles HI/LO busy after DIV/DIVU leaves EX (1..63)
// - CNT_W     32  width of stall performance counter
// PORTS
// - clk            in   1      rising-edge clock
// - rst_n          in   1      asynchronous reset, active low
// - id_rs, id_rt   in   5      source regs of instr in ID
// - id_use_rs/rt   in   1      ID instr actually reads rs / rt
// - id_hilo_rd     in   1      ID instr is MFHI/MFLO/MULT/DIV (needs HI/LO unit)
// - id_jump        in   1      J/JAL/JR resolved in ID
// - ex_dst         in   5      destination reg of instr in EX
// - ex_mem_read    in   1      EX instr is a load
// - ex_br_taken    in   1      branch resolved taken in EX
// - ex_mdu_start   in   1      EX instr starts MULT (0) / DIV (1) per ex_mdu_div
// - ex_mdu_div     in   1      selects DIV_LAT vs MULT_LAT
// - mem_stall      in   1      data memory not ready this cycle
// - pc_we          out  1      PC update enable
// - ifid_we/flush  out  1/1    IF/ID register controls
// - idex_we/flush  out  1/1    ID/EX register controls
// - exmem_we/flush out  1/1    EX/MEM register controls
// - memwb_we/flush out  1/1    MEM/WB register controls
// - mdu_busy       out  1      HI/LO result not yet valid
// - stall_cnt      out  CNT_W  count of cycles with pc_we=0
// BEHAVIOUR
// - Reset (rst_n=0): busy timer=0, state IDLE, stall_cnt=0. All *_we=1, all *_flush=1,
//   pc_we=0, mdu_busy=0, so every pipeline register clears on each clk edge during reset.
// - Default (no hazard): all we=1, all flush=0, pc_we=1.
// - Control outputs are combinational from inputs + state; zero latency.
// - Priority, highest first:
//   1. mem_stall: pc_we=ifid_we=idex_we=exmem_we=0; memwb_we=1, memwb_flush=1 (bubble into WB).
//   2. ex_br_taken: pc_we=1; ifid and idex get we=1, flush=1. Overrides load-use and MDU stalls
//      (the ID instr is wrong-path).
//   3. Load-use, when ex_mem_read && ex_dst!=0 && ((id_use_rs&&id_rs==ex_dst)||(id_use_rt&&id_rt==ex_dst)):
//      pc_we=0, ifid_we=0; idex we=1, flush=1. Exactly one bubble per load.
//   4. MDU stall, when id_hilo_rd && mdu_busy: same outputs as load-use; repeats until the
//      timer expires.
//   5. id_jump (no stall active): ifid we=1, flush=1; pc_we=1.
// - Busy timer FSM:
//   - IDLE -> BUSY on ex_mdu_start && !mem_stall; load timer with (ex_mdu_div ? DIV_LAT : MULT_LAT).
//   - BUSY: decrement every cycle, including during mem_stall; at timer==1 go to IDLE next cycle.
//   - mdu_busy = (state==BUSY).
//   - ex_mdu_start in BUSY reloads the timer (restart); cannot arise if ID interlock is correct.
//   - ex_mdu_start together with ex_br_taken still loads (the branch is older).
// - stall_cnt: +1 each cycle pc_we=0 outside reset; wraps at 2^CNT_W-1 -> 0.
// - Async reset mid-MDU: timer and state clear immediately; mdu_busy falls without waiting
//   for a clock edge.
// STRUCTURE
// - Shared package mips_pipe_pkg: MULT_LAT/DIV_LAT defaults, REG_ZERO=5'd0, FSM state encoding
//   (IDLE/BUSY).
// - One sub-module, mdu_busy_timer: load/decrement counter plus mdu_busy. The top level holds
//   the priority encoder and stall_cnt.
// TESTING
// - Load-use: ex_mem_read=1, ex_dst=8, id_rs=8, id_use_rs=1 -> pc_we=0, ifid_we=0,
//   idex_we=1, idex_flush=1 for 1 cycle; stall_cnt +1.
// - Load to $0: same stimulus with ex_dst=0 -> no stall, all flush=0.
// - Branch vs load-use: ex_br_taken=1 plus a load-use match -> pc_we=1, ifid_flush=1,
//   idex_flush=1, both we=1.
// - DIV interlock: ex_mdu_start=1, ex_mdu_div=1, then id_hilo_rd=1 -> exactly 32 stall cycles,
//   then pc_we=1.
// - mem_stall during MULT busy: assert 3 cycles -> only memwb we=1/flush=1; timer still expires
//   MULT_LAT cycles after start.
// - Reset mid-DIV (timer=20): rst_n=0 -> mdu_busy=0 and all flush=1 immediately; after release
//   -> defaults.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline control blocks: latency defaults,
// the zero register, the MDU busy-timer state encoding and operand-match helper.
package mips_pipe_pkg;

   localparam int MULT_LAT_DEF = 5;
   localparam int DIV_LAT_DEF  = 32;
   localparam int TMR_W        = 6;

   localparam logic [4:0] REG_ZERO = 5'd0;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } mdu_state_e;

   // Writes to $0 are discarded, so a load targeting it never creates a dependency.
   function automatic logic src_match(input logic use_r, input logic [4:0] src,
                                      input logic [4:0] dst);
      return use_r && (src == dst) && (dst != REG_ZERO);
   endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-unit bundle: stage status coming from the datapath and the
// register/PC enables going back to it.
interface pipe_hazard_ctrl_if #(
   parameter int CNT_W = 32
);
   logic [4:0]       id_rs;
   logic [4:0]       id_rt;
   logic             id_use_rs;
   logic             id_use_rt;
   logic             id_hilo_rd;
   logic             id_jump;
   logic [4:0]       ex_dst;
   logic             ex_mem_read;
   logic             ex_br_taken;
   logic             ex_mdu_start;
   logic             ex_mdu_div;
   logic             mem_stall;

   logic             pc_we;
   logic             ifid_we;
   logic             ifid_flush;
   logic             idex_we;
   logic             idex_flush;
   logic             exmem_we;
   logic             exmem_flush;
   logic             memwb_we;
   logic             memwb_flush;
   logic             mdu_busy;
   logic [CNT_W-1:0] stall_cnt;

   modport master (
      output id_rs, id_rt, id_use_rs, id_use_rt, id_hilo_rd, id_jump,
             ex_dst, ex_mem_read, ex_br_taken, ex_mdu_start, ex_mdu_div, mem_stall,
      input  pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush,
             memwb_we, memwb_flush, mdu_busy, stall_cnt
   );

   modport slave (
      input  id_rs, id_rt, id_use_rs, id_use_rt, id_hilo_rd, id_jump,
             ex_dst, ex_mem_read, ex_br_taken, ex_mdu_start, ex_mdu_div, mem_stall,
      output pc_we, ifid_we, ifid_flush, idex_we, idex_flush, exmem_we, exmem_flush,
             memwb_we, memwb_flush, mdu_busy, stall_cnt
   );
endinterface

// File: rtl/mdu_busy_timer.sv
// HI/LO occupancy timer: loads the MULT or DIV latency when an MDU op leaves EX
// and counts down to release.
//   state   | meaning
//   ST_IDLE | HI/LO valid, no MDU op in flight
//   ST_BUSY | MDU op in flight, timer counts remaining cycles
module mdu_busy_timer
   import mips_pipe_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic start,
   input  logic div,
   output logic busy
);

   localparam logic [TMR_W-1:0] MULT_LD = TMR_W'(MULT_LAT);
   localparam logic [TMR_W-1:0] DIV_LD  = TMR_W'(DIV_LAT);

   mdu_state_e       state_q, state_d;
   logic [TMR_W-1:0] timer_q, timer_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         timer_q <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
      end
   end

   // A new start wins over the countdown so a restart while busy reloads cleanly.
   always_comb begin
      state_d = state_q;
      timer_d = timer_q;
      if (start) begin
         state_d = ST_BUSY;
         timer_d = div ? DIV_LD : MULT_LD;
      end else if (state_q == ST_BUSY) begin
         timer_d = timer_q - 1'b1;
         if (timer_q == TMR_W'(1)) state_d = ST_IDLE;
      end
   end

   always_comb begin
      busy = (state_q == ST_BUSY);
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush generator for the 5-stage pipeline: prioritised hazard decode
// driving register/PC enables, plus a count of PC-stalled cycles.
module pipe_hazard_ctrl
   import mips_pipe_pkg::*;
#(
   parameter int MULT_LAT = MULT_LAT_DEF,
   parameter int DIV_LAT  = DIV_LAT_DEF,
   parameter int CNT_W    = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   pipe_hazard_ctrl_if.slave  hz
);

   logic             mdu_busy;
   logic             load_use;
   logic             mdu_stall;
   logic             pc_we;
   logic             ifid_we, ifid_flush;
   logic             idex_we, idex_flush;
   logic             exmem_we, exmem_flush;
   logic             memwb_we, memwb_flush;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   // A frozen EX stage must not hand its MDU op over, so the start waits for memory.
   mdu_busy_timer #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT)
   ) u_mdu_busy_timer (
      .clk   (clk),
      .rst_n (rst_n),
      .start (hz.ex_mdu_start && !hz.mem_stall),
      .div   (hz.ex_mdu_div),
      .busy  (mdu_busy)
   );

   assign load_use  = hz.ex_mem_read &&
                      (src_match(hz.id_use_rs, hz.id_rs, hz.ex_dst) ||
                       src_match(hz.id_use_rt, hz.id_rt, hz.ex_dst));
   assign mdu_stall = hz.id_hilo_rd && mdu_busy;

   // Reset holds every register in clear (we=1, flush=1) and the PC still.
   always_comb begin
      pc_we       = 1'b1;
      ifid_we     = 1'b1;
      ifid_flush  = 1'b0;
      idex_we     = 1'b1;
      idex_flush  = 1'b0;
      exmem_we    = 1'b1;
      exmem_flush = 1'b0;
      memwb_we    = 1'b1;
      memwb_flush = 1'b0;
      if (!rst_n) begin
         pc_we       = 1'b0;
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
         exmem_flush = 1'b1;
         memwb_flush = 1'b1;
      end else if (hz.mem_stall) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_we     = 1'b0;
         exmem_we    = 1'b0;
         memwb_flush = 1'b1;
      end else if (hz.ex_br_taken) begin
         ifid_flush  = 1'b1;
         idex_flush  = 1'b1;
      end else if (load_use || mdu_stall) begin
         pc_we       = 1'b0;
         ifid_we     = 1'b0;
         idex_flush  = 1'b1;
      end else if (hz.id_jump) begin
         ifid_flush  = 1'b1;
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (!pc_we) stall_cnt_d = stall_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stall_cnt_q <= '0;
      else        stall_cnt_q <= stall_cnt_d;
   end

   assign hz.pc_we       = pc_we;
   assign hz.ifid_we     = ifid_we;
   assign hz.ifid_flush  = ifid_flush;
   assign hz.idex_we     = idex_we;
   assign hz.idex_flush  = idex_flush;
   assign hz.exmem_we    = exmem_we;
   assign hz.exmem_flush = exmem_flush;
   assign hz.memwb_we    = memwb_we;
   assign hz.memwb_flush = memwb_flush;
   assign hz.mdu_busy    = mdu_busy;
   assign hz.stall_cnt   = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed hazard scenarios followed by random
// traffic, all checked against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

   localparam int MULT_LAT = 5;
   localparam int DIV_LAT  = 32;
   localparam int CNT_W    = 32;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

   pipe_hazard_ctrl #(
      .MULT_LAT (MULT_LAT),
      .DIV_LAT  (DIV_LAT),
      .CNT_W    (CNT_W)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .hz    (hz)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // model state: remaining busy cycles and expected stall count
   int               rem_m = 0;
   logic [CNT_W-1:0] cnt_m = '0;
   logic             obs_pc_we;
   logic             obs_busy;

   // {pc, ifid we/fl, idex we/fl, exmem we/fl, memwb we/fl}
   localparam logic [8:0] CTL_RST  = 9'b0_11_11_11_11;
   localparam logic [8:0] CTL_DEF  = 9'b1_10_10_10_10;
   localparam logic [8:0] CTL_MEM  = 9'b0_00_00_00_11;
   localparam logic [8:0] CTL_BR   = 9'b1_11_11_10_10;
   localparam logic [8:0] CTL_STL  = 9'b0_00_11_10_10;
   localparam logic [8:0] CTL_JMP  = 9'b1_11_10_10_10;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [8:0] dut_ctl();
      return {hz.pc_we, hz.ifid_we, hz.ifid_flush, hz.idex_we, hz.idex_flush,
              hz.exmem_we, hz.exmem_flush, hz.memwb_we, hz.memwb_flush};
   endfunction

   function automatic logic [8:0] exp_ctl();
      logic dep;
      dep = 1'b0;
      if (hz.ex_mem_read && hz.ex_dst != 5'd0) begin
         if (hz.id_use_rs && hz.id_rs == hz.ex_dst) dep = 1'b1;
         if (hz.id_use_rt && hz.id_rt == hz.ex_dst) dep = 1'b1;
      end
      if (hz.id_hilo_rd && rem_m > 0) dep = 1'b1;
      if (!rst_n)               return CTL_RST;
      if (hz.mem_stall)         return CTL_MEM;
      if (hz.ex_br_taken)       return CTL_BR;
      if (dep)                  return CTL_STL;
      if (hz.id_jump)           return CTL_JMP;
      return CTL_DEF;
   endfunction

   task automatic clear_in();
      hz.id_rs = 5'd0;  hz.id_rt = 5'd0;  hz.id_use_rs = 1'b0; hz.id_use_rt = 1'b0;
      hz.id_hilo_rd = 1'b0; hz.id_jump = 1'b0; hz.ex_dst = 5'd0; hz.ex_mem_read = 1'b0;
      hz.ex_br_taken = 1'b0; hz.ex_mdu_start = 1'b0; hz.ex_mdu_div = 1'b0;
      hz.mem_stall = 1'b0;
   endtask

   // Called at a falling edge with inputs already applied; checks, then advances one clock.
   task automatic step(input string tag);
      logic [8:0] e;
      #1;
      e = exp_ctl();
      obs_pc_we = hz.pc_we;
      obs_busy  = hz.mdu_busy;
      chk({tag, ".ctl"},  64'(dut_ctl()),    64'(e));
      chk({tag, ".busy"}, 64'(hz.mdu_busy),  64'(rem_m > 0));
      chk({tag, ".cnt"},  64'(hz.stall_cnt), 64'(cnt_m));
      @(posedge clk);
      if (!rst_n) begin
         rem_m = 0;
         cnt_m = '0;
      end else begin
         if (!e[8]) cnt_m = cnt_m + 1'b1;
         if (hz.ex_mdu_start && !hz.mem_stall) rem_m = hz.ex_mdu_div ? DIV_LAT : MULT_LAT;
         else if (rem_m > 0) rem_m--;
      end
      @(negedge clk);
   endtask

   initial begin
      int n;
      rst_n = 1'b0;
      clear_in();
      @(negedge clk);
      step("rst0");
      step("rst1");
      rst_n = 1'b1;
      step("idle");

      // load-use on rs
      hz.ex_mem_read = 1'b1; hz.ex_dst = 5'd8; hz.id_rs = 5'd8; hz.id_use_rs = 1'b1;
      step("lu");
      chk("lu_pc_we", 64'(obs_pc_we), 64'd0);
      hz.ex_dst = 5'd0; hz.id_rs = 5'd0;
      step("lu_zero");
      chk("lu_zero_pc_we", 64'(obs_pc_we), 64'd1);
      hz.ex_dst = 5'd8; hz.id_rs = 5'd8; hz.ex_br_taken = 1'b1;
      step("br_lu");
      clear_in();
      step("post_br");

      // DIV interlock: exactly DIV_LAT stall cycles
      hz.ex_mdu_start = 1'b1; hz.ex_mdu_div = 1'b1;
      step("div_start");
      clear_in();
      hz.id_hilo_rd = 1'b1;
      n = 0;
      for (int i = 0; i < 100; i++) begin
         step("div_wait");
         if (obs_pc_we) break;
         n++;
      end
      chk("div_stalls", 64'(n), 64'(DIV_LAT));
      chk("div_release_pc_we", 64'(obs_pc_we), 64'd1);
      clear_in();

      // mem_stall during MULT busy must not extend it
      hz.ex_mdu_start = 1'b1;
      step("mult_start");
      clear_in();
      n = 0;
      for (int i = 0; i < 10; i++) begin
         hz.mem_stall = (i < 3);
         step("mult_ms");
         if (obs_busy) n++;
      end
      chk("mult_busy_len", 64'(n), 64'(MULT_LAT));
      clear_in();

      // async reset mid-DIV with timer at 20
      hz.ex_mdu_start = 1'b1; hz.ex_mdu_div = 1'b1;
      step("div2_start");
      clear_in();
      for (int i = 0; i < 12; i++) step("div2_run");
      chk("div2_busy_pre", 64'(hz.mdu_busy), 64'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("arst_busy", 64'(hz.mdu_busy), 64'd0);
      chk("arst_ctl",  64'(dut_ctl()),   64'(CTL_RST));
      chk("arst_cnt",  64'(hz.stall_cnt), 64'd0);
      rem_m = 0;
      cnt_m = '0;
      @(negedge clk);
      step("arst_hold");
      rst_n = 1'b1;
      step("arst_rel");
      chk("arst_rel_def", 64'(dut_ctl()), 64'(CTL_DEF));

      // random traffic
      for (int i = 0; i < 800; i++) begin
         hz.id_rs        = 5'($urandom_range(0, 3));
         hz.id_rt        = 5'($urandom_range(0, 3));
         hz.id_use_rs    = 1'($urandom_range(0, 1));
         hz.id_use_rt    = 1'($urandom_range(0, 1));
         hz.id_hilo_rd   = ($urandom_range(0, 3) == 0);
         hz.id_jump      = ($urandom_range(0, 7) == 0);
         hz.ex_dst       = 5'($urandom_range(0, 3));
         hz.ex_mem_read  = ($urandom_range(0, 2) == 0);
         hz.ex_br_taken  = ($urandom_range(0, 7) == 0);
         hz.ex_mdu_start = ($urandom_range(0, 15) == 0);
         hz.ex_mdu_div   = 1'($urandom_range(0, 1));
         hz.mem_stall    = ($urandom_range(0, 7) == 0);
         step("rnd");
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
